ps2_key_scanner: RTL and testbench
==================================

PS2_KEY_SCANNER -- requirements
Module: ps2_key_scanner

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter TIMEOUT_US, default 2000, meaning the maximum gap between PS/2 clock falling edges inside one frame, in microseconds.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the event queue depth; it is a power of two and at least 2.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports ps2_clk and ps2_data  input  1 each  raw asynchronous PS/2 lines, idle high.
REQ-007 SHALL have port ev_valid  output  1  the event queue is not empty.
REQ-008 SHALL have port ev_ready  input  1  the consumer accepts the head event.
REQ-009 SHALL have port ev_code  output  8  scan code of the head event.
REQ-010 SHALL have port ev_ext  output  1  the head event was preceded by an E0 prefix.
REQ-011 SHALL have port ev_break  output  1  the head event is a key release (F0 prefix).
REQ-012 SHALL have port frame_err  output  1  one-cycle pulse on a start, parity, stop or timeout error.
REQ-013 SHALL have port overflow  output  1  sticky flag: an event was dropped because the queue was full.
REQ-014 SHALL have port ovf_clr  input  1  synchronous clear of overflow.

Function
REQ-015 SHALL synchronise ps2_clk and ps2_data through 2 flip-flops each (reset value 1), then detect a falling edge as previous=1 and current=0.
REQ-016 SHALL run a frame FSM IDLE->DATA->PARITY->STOP->IDLE that advances only on a detected falling edge and samples the synchronised ps2_data.
REQ-017 SHALL in IDLE accept a start bit of 0 and enter DATA with the bit count at 0; a start bit of 1 SHALL pulse frame_err and remain in IDLE.
REQ-018 SHALL in DATA shift 8 bits LSB first, then enter PARITY.
REQ-019 SHALL in PARITY require odd parity over the 8 data bits plus the parity bit.
REQ-020 SHALL in STOP require the bit to be 1; the byte is delivered only when both parity and stop are correct, otherwise frame_err pulses and the byte is discarded.
REQ-021 SHALL count clk cycles since the last edge while not in IDLE; at CLK_HZ/1000000*TIMEOUT_US cycles it returns to IDLE, pulses frame_err and clears the prefix flags.
REQ-022 SHALL on delivered byte E0 set ext_pend, on F0 set brk_pend, and on any other byte push {ext_pend, brk_pend, byte}, then clear both flags.
REQ-023 SHALL clear both prefix flags on any frame_err.
REQ-024 SHALL assert ev_valid exactly 2 clk cycles after the edge that samples a valid stop bit, provided the queue was empty.
REQ-025 SHALL present the head event show-ahead, pop it on ev_valid && ev_ready, and keep the outputs stable while ev_valid && !ev_ready.
REQ-026 SHALL on a push while full and not popping drop the new event and set overflow; a push and pop in the same cycle while full SHALL both succeed.
REQ-027 SHALL on ovf_clr clear overflow, except that a same-cycle drop wins and keeps overflow set.
REQ-028 SHALL wrap the FIFO pointers modulo FIFO_DEPTH and use an extra bit to distinguish full from empty.

Reset
REQ-029 SHALL while rst=0 force FSM=IDLE, all counters=0, prefix flags=0, queue empty, ev_valid=0, ev_code=0, ev_ext=0, ev_break=0, frame_err=0, overflow=0.
REQ-030 SHALL on reset in mid-frame discard the partial frame and produce no frame_err after release.

Structure
REQ-031 SHALL take the FSM state encoding, the E0/F0 constants and the event width (10 bits) from shared package ps2_pkg.
REQ-032 SHALL instantiate the queue as sub-module ps2_event_fifo (parameters WIDTH and DEPTH).

Verification
REQ-033 SHALL check: frame 0x1D with good parity, ev_ready=1 -> one event {ext=0, brk=0, code=1D}, ev_valid high 2 cycles after the stop edge.
REQ-034 SHALL check: bytes E0, F0, 75 -> single event {ext=1, brk=1, code=75}.
REQ-035 SHALL check: 0x1C with the parity bit flipped -> frame_err pulse, no event; a following 0x23 -> event code 23 with no stale prefix.
REQ-036 SHALL check: 4 bits of a frame then silence for >2 ms -> frame_err, FSM in IDLE; the next full frame decodes correctly.
REQ-037 SHALL check: ev_ready=0 with FIFO_DEPTH=4 and 5 make codes -> first 4 retained in order, overflow=1; ovf_clr -> overflow=0.
REQ-038 SHALL check: rst asserted mid-frame -> all outputs at reset values; a clean frame after release decodes.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 key scanner.
//   ps2_state_t : frame receiver state encoding
//   PS2_EXT/BRK : E0 (extended) and F0 (break) prefix bytes
//   ps2_event_t : queued event {ext, brk, code}, EV_W bits wide
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam int unsigned EV_W = 10;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  // Odd parity holds when data plus parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_key_scanner_if.sv
// Event stream handshake of the PS/2 key scanner.
//   ev_valid : head event present      ev_ready : consumer accepts head
//   ev_code  : scan code               ev_ext   : E0-prefixed
//   ev_break : key release (F0)
// master = scanner side, slave = consumer side.
interface ps2_key_scanner_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;

  modport master (output ev_valid, ev_code, ev_ext, ev_break, input ev_ready);
  modport slave  (input ev_valid, ev_code, ev_ext, ev_break, output ev_ready);
endinterface

// File: rtl/ps2_event_fifo.sv
// Show-ahead event queue.
//   push/push_data : write request (dropped when full and not popping)
//   pop            : remove head (ignored when empty)
//   head           : current head entry, empty : queue empty
//   drop           : one-cycle indication that a push was discarded
module ps2_event_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr, rptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full, wr_en, rd_en;

  // Extra MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);
  assign drop  = push && full && !rd_en;
  assign head  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wptr[AW-1:0]] <= push_data;
        wptr <= wptr + 1'b1;
      end
      if (rd_en) rptr <= rptr + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_key_scanner.sv
// PS/2 keyboard frame receiver and scan-code event generator.
//   clk, rst        : system clock, async active-low reset
//   ps2_clk/data    : raw PS/2 lines (idle high)
//   ev              : event stream (master modport)
//   frame_err       : one-cycle pulse on start/parity/stop/timeout error
//   overflow        : sticky event-dropped flag, ovf_clr clears it
module ps2_key_scanner
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned TIMEOUT_US = 2000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  ps2_key_scanner_if.master  ev,
  output logic               frame_err,
  output logic               overflow,
  input  logic               ovf_clr
);

  localparam int unsigned LIMIT = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int unsigned TW    = $clog2(LIMIT + 1);

  logic [1:0]  clk_sync, dat_sync;
  logic        clk_prev, fall;
  ps2_state_t  state;
  logic [2:0]  bcnt;
  logic [7:0]  shreg;
  logic        par_ok, byte_vld;
  logic [TW-1:0] tcnt;
  logic        ext_pend, brk_pend, push_vld;
  ps2_event_t  push_ev, head_ev;
  logic        empty, drop, pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync <= '1;
      dat_sync <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      clk_prev <= clk_sync[1];
    end
  end

  assign fall = clk_prev && !clk_sync[1];

  // Frame receiver; shreg holds the byte while byte_vld is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      bcnt      <= '0;
      shreg     <= '0;
      par_ok    <= 1'b0;
      tcnt      <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      if (state == ST_IDLE || fall) tcnt <= '0;
      else                          tcnt <= tcnt + 1'b1;
      if (fall) begin
        case (state)
          ST_IDLE: begin
            if (!dat_sync[1]) begin
              state <= ST_DATA;
              bcnt  <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          ST_DATA: begin
            shreg <= {dat_sync[1], shreg[7:1]};
            bcnt  <= bcnt + 3'd1;
            if (bcnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
            par_ok <= odd_parity_ok(shreg, dat_sync[1]);
            state  <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (dat_sync[1] && par_ok) byte_vld  <= 1'b1;
            else                       frame_err <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE && tcnt == TW'(LIMIT - 1)) begin
        state     <= ST_IDLE;
        frame_err <= 1'b1;
      end
    end
  end

  // Prefix tracking; a completed event is registered before the queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
      push_vld <= 1'b0;
      push_ev  <= '0;
    end else begin
      push_vld <= 1'b0;
      if (frame_err) begin
        ext_pend <= 1'b0;
        brk_pend <= 1'b0;
      end else if (byte_vld) begin
        if (shreg == PS2_EXT) begin
          ext_pend <= 1'b1;
        end else if (shreg == PS2_BRK) begin
          brk_pend <= 1'b1;
        end else begin
          push_vld <= 1'b1;
          push_ev  <= '{ext: ext_pend, brk: brk_pend, code: shreg};
          ext_pend <= 1'b0;
          brk_pend <= 1'b0;
        end
      end
    end
  end

  assign pop = !empty && ev.ev_ready;

  ps2_event_fifo #(.WIDTH(EV_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_vld),
    .push_data (push_ev),
    .pop       (pop),
    .head      (head_ev),
    .empty     (empty),
    .drop      (drop)
  );

  assign ev.ev_valid = !empty;
  assign ev.ev_code  = head_ev.code;
  assign ev.ev_ext   = head_ev.ext;
  assign ev.ev_break = head_ev.brk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_ps2_key_scanner.sv
module tb_ps2_key_scanner;
  import ps2_pkg::*;

  localparam int HALF = 20;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic ovf_clr = 1'b0;
  logic frame_err, overflow;

  ps2_key_scanner_if evif ();

  ps2_key_scanner #(.CLK_HZ(1000000), .TIMEOUT_US(2000), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ev        (evif.master),
    .frame_err (frame_err),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;
  logic [9:0] evq [$];

  always @(negedge clk) begin
    if (rst) begin
      if (frame_err) err_cnt++;
      if (evif.ev_valid && evif.ev_ready)
        evq.push_back({evif.ev_ext, evif.ev_break, evif.ev_code});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] code, input logic pflip, input logic sbad);
    return {~sbad, (~^code) ^ pflip, code, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] code);
    send_bits(mk_frame(code, 1'b0, 1'b0), 11);
    repeat (10) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] code;
    logic       pflip;
    logic       sbad;
    int         n_ev;
    int         n_err;
    logic [9:0] ev;
  } vec_t;

  vec_t vt [13];

  initial begin
    int n0, e0;
    logic [10:0] f;
    logic [7:0] ovf_codes [5];

    vt[0]  = '{8'h1D, 0, 0, 1, 0, {2'b00, 8'h1D}};
    vt[1]  = '{8'hE0, 0, 0, 0, 0, 10'h0};
    vt[2]  = '{8'hF0, 0, 0, 0, 0, 10'h0};
    vt[3]  = '{8'h75, 0, 0, 1, 0, {2'b11, 8'h75}};
    vt[4]  = '{8'h1C, 1, 0, 0, 1, 10'h0};
    vt[5]  = '{8'h23, 0, 0, 1, 0, {2'b00, 8'h23}};
    vt[6]  = '{8'hE0, 0, 0, 0, 0, 10'h0};
    vt[7]  = '{8'h1C, 0, 1, 0, 1, 10'h0};
    vt[8]  = '{8'h23, 0, 0, 1, 0, {2'b00, 8'h23}};
    vt[9]  = '{8'hF0, 0, 0, 0, 0, 10'h0};
    vt[10] = '{8'h1C, 0, 0, 1, 0, {2'b01, 8'h1C}};
    vt[11] = '{8'hE0, 0, 0, 0, 0, 10'h0};
    vt[12] = '{8'h6B, 0, 0, 1, 0, {2'b10, 8'h6B}};

    evif.ev_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, evif.ev_valid}, 0);
    chk("rst_code", {24'd0, evif.ev_code}, 0);
    chk("rst_ext_brk", {30'd0, evif.ev_ext, evif.ev_break}, 0);
    chk("rst_err_ovf", {30'd0, frame_err, overflow}, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Latency: ev_valid rises on the 5th clk edge after the stop-bit fall
    // (2 sync + sampling edge + 2 pipeline edges).
    f = mk_frame(8'h1D, 1'b0, 1'b0);
    n0 = evq.size();
    send_bits(f, 10);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("lat_early", {31'd0, evif.ev_valid}, 0);
    @(posedge clk);
    #1 chk("lat_on_time", {31'd0, evif.ev_valid}, 1);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
    chk("lat_count", evq.size() - n0, 1);
    if (evq.size() > n0) chk("lat_event", {22'd0, evq[$]}, {22'd0, 2'b00, 8'h1D});

    for (int i = 0; i < 13; i++) begin
      n0 = evq.size();
      e0 = err_cnt;
      send_bits(mk_frame(vt[i].code, vt[i].pflip, vt[i].sbad), 11);
      repeat (10) @(negedge clk);
      chk($sformatf("vec%0d_events", i), evq.size() - n0, vt[i].n_ev);
      chk($sformatf("vec%0d_errs", i), err_cnt - e0, vt[i].n_err);
      if (vt[i].n_ev == 1 && evq.size() > n0)
        chk($sformatf("vec%0d_event", i), {22'd0, evq[$]}, {22'd0, vt[i].ev});
    end

    // Start bit of 1 is rejected.
    n0 = evq.size();
    e0 = err_cnt;
    send_bits(11'h7FF, 1);
    repeat (10) @(negedge clk);
    chk("bad_start_err", err_cnt - e0, 1);
    chk("bad_start_ev", evq.size() - n0, 0);

    // Timeout after a partial frame (E0 prefix pending must be dropped).
    send_byte(8'hE0);
    n0 = evq.size();
    e0 = err_cnt;
    send_bits(mk_frame(8'h55, 1'b0, 1'b0), 4);
    repeat (2500) @(negedge clk);
    chk("tmo_err", err_cnt - e0, 1);
    chk("tmo_idle", {30'd0, dut.state}, {30'd0, ST_IDLE});
    send_byte(8'h2B);
    chk("tmo_next_count", evq.size() - n0, 1);
    if (evq.size() > n0) chk("tmo_next_event", {22'd0, evq[$]}, {22'd0, 2'b00, 8'h2B});

    // Overflow with the consumer stalled.
    ovf_codes = '{8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
    evif.ev_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(ovf_codes[i]);
    chk("ovf_not_yet", {31'd0, overflow}, 0);
    chk("ovf_stable_head", {24'd0, evif.ev_code}, {24'd0, 8'h15});
    send_byte(ovf_codes[4]);
    chk("ovf_set", {31'd0, overflow}, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("ovf_valid%0d", i), {31'd0, evif.ev_valid}, 1);
      chk($sformatf("ovf_code%0d", i), {24'd0, evif.ev_code}, {24'd0, ovf_codes[i]});
      evif.ev_ready = 1'b1;
      @(negedge clk);
      evif.ev_ready = 1'b0;
    end
    @(negedge clk);
    chk("ovf_drained", {31'd0, evif.ev_valid}, 0);
    chk("ovf_sticky", {31'd0, overflow}, 1);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    chk("ovf_cleared", {31'd0, overflow}, 0);

    // Reset in mid-frame with an event queued.
    send_byte(8'h33);
    chk("pre_rst_valid", {31'd0, evif.ev_valid}, 1);
    send_bits(mk_frame(8'h44, 1'b0, 1'b0), 5);
    @(negedge clk);
    rst = 1'b0;
    ps2_data = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, evif.ev_valid}, 0);
    chk("mid_rst_code", {24'd0, evif.ev_code}, 0);
    chk("mid_rst_flags", {29'd0, evif.ev_ext, evif.ev_break, frame_err}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    evif.ev_ready = 1'b1;
    n0 = evq.size();
    e0 = err_cnt;
    repeat (2500) @(negedge clk);
    chk("post_rst_no_err", err_cnt - e0, 0);
    send_byte(8'h4D);
    chk("post_rst_count", evq.size() - n0, 1);
    if (evq.size() > n0) chk("post_rst_event", {22'd0, evq[$]}, {22'd0, 2'b00, 8'h4D});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
